// File: rtl/slice_rd_sched.sv
// rtl/slice_rd_sched.sv - per-slice output FIFO read scheduler, slice-interleaved line order
module slice_rd_sched #(
    parameter int MAX_NBR_SLICES   = 2,
    parameter int MAX_SLICE_WIDTH  = 2560,
    parameter int MAX_SLICE_HEIGHT = 2560,
    localparam int SEL_W = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1,
    localparam int SW_W  = $clog2(MAX_SLICE_WIDTH)
) (
    input  logic                      clk_out_int,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      frame_start,
    input  logic [9:0]                slices_per_line,
    input  logic [SW_W-1:0]           slice_width,
    input  logic [15:0]               frame_height,
    input  logic [7:0]                h_blank,
    input  logic [MAX_NBR_SLICES-1:0] fifo_empty,
    output logic [MAX_NBR_SLICES-1:0] rd_en,
    output logic [SEL_W-1:0]          rd_sel,
    output logic                      chunk_last,
    output logic [15:0]               line_cnt,
    output logic                      frame_done,
    output logic                      busy
);

    localparam int GRP_W  = $clog2(MAX_SLICE_WIDTH / 4 + 4);
    localparam int LINE_W = $clog2(MAX_SLICE_HEIGHT + 1);
    localparam int CMP_W  = (SW_W > GRP_W) ? SW_W : GRP_W;

    typedef enum logic [1:0] {IDLE, READ, HBLANK, DONE} state_t;

    state_t             state, state_nx;
    logic [GRP_W-1:0]   grp_cnt, grp_nx;
    logic [SEL_W-1:0]   sel_q, sel_nx;
    logic [LINE_W-1:0]  line_q, line_nx;
    logic [7:0]         blank_cnt, blank_nx;
    logic               frame_done_q, busy_q;

    logic [CMP_W-1:0]   grp_ext, grp_max;
    logic               pop, sel_last, line_last;

    assign grp_ext   = CMP_W'(grp_cnt);
    assign grp_max   = CMP_W'(slice_width >> 2) - CMP_W'(1);
    // Only the selected slice's empty flag matters, so inactive slices never stall
    assign pop       = (state == READ) && !fifo_empty[sel_q];
    assign sel_last  = (10'(sel_q) == slices_per_line - 10'd1);
    assign line_last = (16'(line_q) == frame_height - 16'd1);

    always_comb begin
        rd_en = '0;
        for (int s = 0; s < MAX_NBR_SLICES; s++) begin
            rd_en[s] = (state == READ) && (sel_q == SEL_W'(s)) && !fifo_empty[s];
        end
    end

    assign chunk_last = pop && (grp_ext == grp_max);

    always_comb begin
        state_nx = state;
        grp_nx   = grp_cnt;
        sel_nx   = sel_q;
        line_nx  = line_q;
        blank_nx = blank_cnt;
        if (flush) begin
            state_nx = IDLE;
            grp_nx   = '0;
            sel_nx   = '0;
            line_nx  = '0;
            blank_nx = '0;
        end else if (frame_start) begin
            // Restart wins even over a coinciding chunk_last; that pop still goes out
            state_nx = READ;
            grp_nx   = '0;
            sel_nx   = '0;
            line_nx  = '0;
            blank_nx = '0;
        end else begin
            case (state)
                READ: begin
                    if (pop) begin
                        if (chunk_last) begin
                            grp_nx = '0;
                            if (!sel_last) begin
                                sel_nx = sel_q + SEL_W'(1);
                            end else begin
                                sel_nx = '0;
                                if (line_last) begin
                                    state_nx = DONE;
                                end else begin
                                    line_nx = line_q + LINE_W'(1);
                                    if (h_blank != 8'd0) state_nx = HBLANK;
                                end
                            end
                        end else begin
                            grp_nx = grp_cnt + GRP_W'(1);
                        end
                    end
                end
                HBLANK: begin
                    if (blank_cnt == h_blank - 8'd1) begin
                        blank_nx = '0;
                        state_nx = READ;
                    end else begin
                        blank_nx = blank_cnt + 8'd1;
                    end
                end
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_out_int or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grp_cnt      <= '0;
            sel_q        <= '0;
            line_q       <= '0;
            blank_cnt    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_nx;
            grp_cnt      <= grp_nx;
            sel_q        <= sel_nx;
            line_q       <= line_nx;
            blank_cnt    <= blank_nx;
            frame_done_q <= (state_nx == DONE);
            busy_q       <= (state_nx != IDLE);
        end
    end

    assign rd_sel     = sel_q;
    assign line_cnt   = 16'(line_q);
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: doc/slice_rd_sched.md
SLICE_RD_SCHED -- requirements
Module: slice_rd_sched

Interface
REQ-001 SHALL have parameter MAX_NBR_SLICES, default 2, max slices per line.
REQ-002 SHALL have parameter MAX_SLICE_WIDTH, default 2560, max slice width in pixels.
REQ-003 SHALL have parameter MAX_SLICE_HEIGHT, default 2560, max slice height in lines. Used only to size counter widths.
REQ-004 SHALL have port clk_out_int  input  1  output pixel clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous abort to IDLE.
REQ-007 SHALL have port frame_start  input  1  single-cycle pulse; the first group of a new frame is available.
REQ-008 SHALL have port slices_per_line  input  10  active slices per line; legal range 1..MAX_NBR_SLICES.
REQ-009 SHALL have port slice_width  input  $clog2(MAX_SLICE_WIDTH)  pixels per slice; a multiple of 4 and at least 8.
REQ-010 SHALL have port frame_height  input  16  lines per frame; at least 1.
REQ-011 SHALL have port h_blank  input  8  idle cycles inserted after each completed line.
REQ-012 SHALL have port fifo_empty  input  MAX_NBR_SLICES  per-slice output FIFO empty flags.
REQ-013 SHALL have port rd_en  output  MAX_NBR_SLICES  one-hot per-slice FIFO read strobe.
REQ-014 SHALL have port rd_sel  output  $clog2(MAX_NBR_SLICES)  index of the slice currently being read.
REQ-015 SHALL have port chunk_last  output  1  the current rd_en pops the last 4-pixel group of a slice chunk.
REQ-016 SHALL have port line_cnt  output  16  index of the line currently being read.
REQ-017 SHALL have port frame_done  output  1  single-cycle pulse after the last group of a frame is popped.
REQ-018 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, READ, HBLANK and DONE.
REQ-020 SHALL hold internal counters grp_cnt (width $clog2(MAX_SLICE_WIDTH/4+4)), rd_sel, line_cnt and blank_cnt (8 bits).
REQ-021 SHALL, on frame_start in any state, go to READ next cycle with grp_cnt, rd_sel, line_cnt and blank_cnt all 0.
REQ-022 SHALL give flush priority over frame_start: go to IDLE and clear all counters.
REQ-023 SHALL drive rd_en[s] combinationally as (state==READ) & (rd_sel==s) & ~fifo_empty[s], with zero latency.
REQ-024 SHALL, when fifo_empty[rd_sel] is high in READ, stall: counters hold, rd_en=0, and the state stays READ.
REQ-025 SHALL drive chunk_last combinationally as rd_en[rd_sel] & (grp_cnt == (slice_width>>2)-1).
REQ-026 SHALL, on rd_en without chunk_last, increment grp_cnt.
REQ-027 SHALL, on chunk_last when rd_sel < slices_per_line-1: set grp_cnt to 0 and increment rd_sel.
REQ-028 SHALL, on chunk_last when rd_sel == slices_per_line-1 (line end): set grp_cnt to 0 and rd_sel to 0.
REQ-029 SHALL, at line end when line_cnt == frame_height-1, go to DONE.
REQ-030 SHALL, at line end otherwise, increment line_cnt; go to HBLANK if h_blank != 0, else stay in READ.
REQ-031 SHALL, in HBLANK, increment blank_cnt each cycle, with rd_en=0.
REQ-032 SHALL, in HBLANK when blank_cnt == h_blank-1, clear blank_cnt and return to READ.
REQ-033 SHALL, in DONE, assert frame_done for exactly one cycle, then go to IDLE.
REQ-034 SHALL register frame_done and busy; line_cnt and rd_sel are the register values.
REQ-035 SHALL leave the FSM and counters unaffected by fifo_empty bits of slices >= slices_per_line.
REQ-036 SHALL support a frame_start that coincides with chunk_last: the restart wins and the pop is still issued.
REQ-037 SHALL treat configuration inputs as static while busy; changing them while busy is undefined.

Reset
REQ-038 SHALL, on rst_n low, asynchronously force state IDLE and grp_cnt, rd_sel, line_cnt and blank_cnt to 0.
REQ-039 SHALL, during reset, drive rd_en=0, chunk_last=0, frame_done=0 and busy=0.
REQ-040 SHALL, on reset assertion mid-frame, abandon the frame with no frame_done pulse.

Verification
REQ-041 SHALL cover: 2 slices, width 16, height 2, h_blank 0, FIFOs never empty → rd_en pattern 4×01, 4×10, 4×01, 4×10 over 16 consecutive cycles; chunk_last on cycles 4, 8, 12, 16; frame_done one cycle after cycle 16.
REQ-042 SHALL cover: same configuration with h_blank=3 → exactly 3 cycles of rd_en=0 between line 0 and line 1; line_cnt=1 from the first line-1 pop onward.
REQ-043 SHALL cover: fifo_empty[1] held high for 5 cycles at the start of slice 1 → rd_en=0 and rd_sel=1 for those 5 cycles; total pop count unchanged at 16.
REQ-044 SHALL cover: slices_per_line=1 with MAX_NBR_SLICES=2 and fifo_empty[1]=1 → rd_en[1] never asserted; frame completes.
REQ-045 SHALL cover: flush asserted together with frame_start mid-line → IDLE next cycle, busy=0, no frame_done pulse.
REQ-046 SHALL cover: frame_start pulsed mid-frame at line 1, group 2 → next cycle rd_sel=0, line_cnt=0, grp_cnt=0, and a full frame follows.
